// File: rtl/control_pipe.sv
// Pipelined main control for the 5-stage MIPS core: ID decode into ID/EX with bubbles,
// plus a DIVU sequencer and HI/LO interlock built only when CONTROL_HILO_EN is defined.
//
//   state | meaning
//   IDLE  | no divide in flight, cnt = 0
//   RUN   | DIVU executing, cnt counts down to 0
module control_pipe #(
  parameter int ALUOP_W = 3,
  parameter int DIV_LAT = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               stall,
  input  logic               flush,
  output logic               stall_req,
  output logic               ex_reg_dst,
  output logic               ex_alu_src,
  output logic               ex_mem_to_reg,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_branch,
  output logic               ex_bne,
  output logic               ex_jump,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [1:0]         ex_hilo_rd,
  output logic               ex_div_start,
  output logic               div_busy,
  output logic               ex_illegal
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic               mem_to_reg;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic               bne;
    logic               jump;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         hilo_rd;
    logic               div_start;
    logic               illegal;
  } ctrl_t;

  ctrl_t dec;
  ctrl_t ex_d, ex_q;
  logic  stall_req_int;

`ifdef CONTROL_HILO_EN
  localparam logic [5:0] FN_MFHI = 6'd16;
  localparam logic [5:0] FN_MFLO = 6'd18;
  localparam logic [5:0] FN_DIVU = 6'd27;

  typedef enum logic {S_IDLE, S_RUN} div_state_t;

  div_state_t       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             busy_d, busy_q;
  logic             hilo_op;
`endif

  always_comb begin
    dec = '0;
    unique case (opcode)
      OP_RTYPE: begin
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOP_W'(2);
`ifdef CONTROL_HILO_EN
        if (funct == FN_DIVU) begin
          dec.reg_dst   = 1'b0;
          dec.reg_write = 1'b0;
          dec.div_start = 1'b1;
        end else if (funct == FN_MFHI) begin
          dec.alu_op  = '0;
          dec.hilo_rd = 2'b10;
        end else if (funct == FN_MFLO) begin
          dec.alu_op  = '0;
          dec.hilo_rd = 2'b01;
        end
`endif
      end
      OP_LW: begin
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
      end
      OP_SW: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.alu_op = ALUOP_W'(1);
      end
      OP_BNE: begin
        dec.branch = 1'b1;
        dec.bne    = 1'b1;
        dec.alu_op = ALUOP_W'(1);
      end
      OP_J:    dec.jump = 1'b1;
      OP_ORI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALUOP_W'(3);
      end
      default: dec.illegal = 1'b1;
    endcase
  end

`ifdef CONTROL_HILO_EN
  // Only instructions that touch HI/LO or restart the divider wait for it.
  assign hilo_op = (opcode == OP_RTYPE) &&
                   ((funct == FN_DIVU) || (funct == FN_MFHI) || (funct == FN_MFLO));
  assign stall_req_int = id_valid & busy_q & hilo_op & ~flush;
`else
  logic             unused_funct;
  logic [CNT_W-1:0] unused_div_lat;
  assign unused_funct   = ^funct;
  assign unused_div_lat = CNT_W'(DIV_LAT);
  assign stall_req_int  = 1'b0;
`endif

  always_comb begin
    ex_d = '0;
    if (!flush && !(stall || stall_req_int) && id_valid) ex_d = dec;
  end

`ifdef CONTROL_HILO_EN
  // A flushed or stalled DIVU never reaches ex_d, so it never starts the counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (ex_d.div_start) begin
          cnt_d   = CNT_W'(DIV_LAT);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (ex_d.div_start) begin
          cnt_d = CNT_W'(DIV_LAT);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (cnt_d != '0);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
`ifdef CONTROL_HILO_EN
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
`endif
    end else begin
      ex_q    <= ex_d;
`ifdef CONTROL_HILO_EN
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
`endif
    end
  end

  assign stall_req     = stall_req_int;
  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_branch     = ex_q.branch;
  assign ex_bne        = ex_q.bne;
  assign ex_jump       = ex_q.jump;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_illegal    = ex_q.illegal;
`ifdef CONTROL_HILO_EN
  assign ex_hilo_rd    = ex_q.hilo_rd;
  assign ex_div_start  = ex_q.div_start;
  assign div_busy      = busy_q;
`else
  assign ex_hilo_rd    = 2'b00;
  assign ex_div_start  = 1'b0;
  assign div_busy      = 1'b0;
`endif

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe (DIV_LAT=4); expectations follow CONTROL_HILO_EN.
module tb_control_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       stall;
  logic       flush;
  logic       stall_req;
  logic       ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read;
  logic       ex_mem_write, ex_branch, ex_bne, ex_jump;
  logic [2:0] ex_alu_op;
  logic [1:0] ex_hilo_rd;
  logic       ex_div_start, div_busy, ex_illegal;

  int passes = 0;
  int total  = 0;
  int fails  = 0;

  control_pipe #(.ALUOP_W(3), .DIV_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .funct(funct),
    .stall(stall), .flush(flush), .stall_req(stall_req),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_bne(ex_bne), .ex_jump(ex_jump), .ex_alu_op(ex_alu_op),
    .ex_hilo_rd(ex_hilo_rd), .ex_div_start(ex_div_start), .div_busy(div_busy),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  wire [15:0] obs = {ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read,
                     ex_mem_write, ex_branch, ex_bne, ex_jump, ex_alu_op, ex_hilo_rd,
                     ex_div_start, ex_illegal};

  // Field order: rd as mr rw mrd mw br bne j alu_op[3] hilo[2] ds ill
  localparam logic [15:0] B_NONE = 16'b0_0_0_0_0_0_0_0_0_000_00_0_0;
  localparam logic [15:0] B_LW   = 16'b0_1_1_1_1_0_0_0_0_000_00_0_0;
  localparam logic [15:0] B_SW   = 16'b0_1_0_0_0_1_0_0_0_000_00_0_0;
  localparam logic [15:0] B_BEQ  = 16'b0_0_0_0_0_0_1_0_0_001_00_0_0;
  localparam logic [15:0] B_BNE  = 16'b0_0_0_0_0_0_1_1_0_001_00_0_0;
  localparam logic [15:0] B_J    = 16'b0_0_0_0_0_0_0_0_1_000_00_0_0;
  localparam logic [15:0] B_ORI  = 16'b0_1_0_1_0_0_0_0_0_011_00_0_0;
  localparam logic [15:0] B_RTY  = 16'b1_0_0_1_0_0_0_0_0_010_00_0_0;
  localparam logic [15:0] B_ILL  = 16'b0_0_0_0_0_0_0_0_0_000_00_0_1;
`ifdef CONTROL_HILO_EN
  localparam logic [15:0] B_DIVU = 16'b0_0_0_0_0_0_0_0_0_010_00_1_0;
  localparam logic [15:0] B_MFHI = 16'b1_0_0_1_0_0_0_0_0_000_10_0_0;
  localparam logic [15:0] B_MFLO = 16'b1_0_0_1_0_0_0_0_0_000_01_0_0;
  localparam logic        HILO   = 1'b1;
`else
  localparam logic [15:0] B_DIVU = B_RTY;
  localparam logic [15:0] B_MFHI = B_RTY;
  localparam logic [15:0] B_MFLO = B_RTY;
  localparam logic        HILO   = 1'b0;
`endif

  task automatic chk16(input string tag, input logic [15:0] o, input logic [15:0] e);
    total++;
    assert (o === e) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic chk1(input string tag, input logic o, input logic e);
    total++;
    assert (o === e) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic st, input logic fl);
    id_valid = v;
    opcode   = op;
    funct    = fn;
    stall    = st;
    flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk16("reset_bundle", obs, B_NONE);
    chk1("reset_busy", div_busy, 1'b0);
    chk1("reset_stall_req", stall_req, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Basic decode, one instruction per cycle
    drive(1'b1, 6'd35, 6'd0, 1'b0, 1'b0); tick(); chk16("lw", obs, B_LW);
    drive(1'b1, 6'd43, 6'd0, 1'b0, 1'b0); tick(); chk16("sw", obs, B_SW);
    drive(1'b1, 6'd4, 6'd0, 1'b0, 1'b0);  tick(); chk16("beq", obs, B_BEQ);
    drive(1'b1, 6'd5, 6'd0, 1'b0, 1'b0);  tick(); chk16("bne", obs, B_BNE);
    drive(1'b1, 6'd2, 6'd0, 1'b0, 1'b0);  tick(); chk16("j", obs, B_J);
    drive(1'b1, 6'd13, 6'd0, 1'b0, 1'b0); tick(); chk16("ori", obs, B_ORI);
    drive(1'b1, 6'd0, 6'd32, 1'b0, 1'b0); tick(); chk16("add", obs, B_RTY);

    // Illegal opcode for one cycle
    drive(1'b1, 6'd63, 6'd0, 1'b0, 1'b0); tick(); chk16("illegal", obs, B_ILL);
    drive(1'b0, 6'd63, 6'd0, 1'b0, 1'b0); tick(); chk16("illegal_clear", obs, B_NONE);

    // DIVU then MFHI
    drive(1'b1, 6'd0, 6'd27, 1'b0, 1'b0); tick();
    chk16("divu", obs, B_DIVU);
    chk1("busy_c1", div_busy, HILO);
    drive(1'b1, 6'd0, 6'd16, 1'b0, 1'b0); #1;
    chk1("stall_req_c1", stall_req, HILO);
    if (HILO) begin
      tick(); chk16("mfhi_wait2", obs, B_NONE); chk1("busy_c2", div_busy, 1'b1);
      chk1("stall_req_c2", stall_req, 1'b1);
      tick(); chk16("mfhi_wait3", obs, B_NONE); chk1("busy_c3", div_busy, 1'b1);
      chk1("stall_req_c3", stall_req, 1'b1);
      tick(); chk16("mfhi_wait4", obs, B_NONE); chk1("busy_c4", div_busy, 1'b1);
      chk1("stall_req_c4", stall_req, 1'b1);
      tick(); chk16("mfhi_wait5", obs, B_NONE); chk1("busy_c5", div_busy, 1'b0);
      chk1("stall_req_c5", stall_req, 1'b0);
    end
    tick(); chk16("mfhi", obs, B_MFHI);
    chk1("busy_after_mfhi", div_busy, 1'b0);
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0); tick();

    // Flush and stall
    drive(1'b1, 6'd0, 6'd27, 1'b0, 1'b1); #1;
    chk1("flush_divu_stall_req", stall_req, 1'b0);
    tick(); chk16("flush_divu", obs, B_NONE); chk1("flush_divu_busy", div_busy, 1'b0);
    drive(1'b1, 6'd0, 6'd32, 1'b1, 1'b1); tick(); chk16("stall_and_flush", obs, B_NONE);
    drive(1'b1, 6'd35, 6'd0, 1'b1, 1'b0);
    tick(); chk16("stall_lw1", obs, B_NONE);
    tick(); chk16("stall_lw2", obs, B_NONE);
    tick(); chk16("stall_lw3", obs, B_NONE);
    drive(1'b1, 6'd35, 6'd0, 1'b0, 1'b0); tick(); chk16("lw_release", obs, B_LW);
    drive(1'b0, 6'd35, 6'd0, 1'b0, 1'b0); tick(); chk16("lw_once", obs, B_NONE);

    // Reset mid-divide; ORI proceeds under the running divide
    drive(1'b1, 6'd0, 6'd27, 1'b0, 1'b0); tick(); chk16("divu2", obs, B_DIVU);
    drive(1'b1, 6'd13, 6'd0, 1'b0, 1'b0); tick(); chk16("ori_under_div", obs, B_ORI);
    tick(); chk16("ori_under_div2", obs, B_ORI);
    chk1("busy_cnt2", div_busy, HILO);
    #3 rst_n = 1'b0;
    #1;
    chk16("midreset_bundle", obs, B_NONE);
    chk1("midreset_busy", div_busy, 1'b0);
    chk1("midreset_stall_req", stall_req, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1'b1, 6'd0, 6'd18, 1'b0, 1'b0); #1;
    chk1("mflo_stall_req", stall_req, 1'b0);
    tick(); chk16("mflo", obs, B_MFLO);
    chk1("mflo_busy", div_busy, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
